// File: rtl/oven_pkg.sv
// Shared types and constants for the oven cook-time datapath.
package oven_pkg;

    // Countdown controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One packed BCD digit
    typedef logic [3:0] bcd_t;

    // Largest legal BCD digit; also the wrap value for a plain digit borrow
    localparam bcd_t BCD_MAX         = 4'd9;

    // Smallest key code that is not a digit (function keys, no-key codes)
    localparam bcd_t KEY_INVALID_MIN = 4'd10;

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer with borrow chain.
// When borrowed from, a zero digit reloads 'wrap' and passes the borrow on;
// a nonzero digit simply decrements and absorbs the borrow.
module bcd_digit_dec
    import oven_pkg::*;
(
    input  bcd_t digit,
    input  logic borrow_in,
    input  bcd_t wrap,
    output bcd_t next_digit,
    output logic borrow_out
);

    // Combinational decrement of one digit
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = wrap;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD cook-time register with keypad entry and 1 Hz countdown.
// Optional build macro TIMER_DONE_PULSE_EN adds a one-clock 'done' pulse
// in the cycle the controller enters DONE.
module bcd_countdown_timer
    import oven_pkg::*;
#(
    parameter bcd_t SEC_TENS_WRAP = 4'd5,
    parameter bcd_t SEC_ONES_WRAP = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       count_en,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       running
`ifdef TIMER_DONE_PULSE_EN
    ,
    output logic       done
`endif
);

    state_t state;
    state_t next_state;

    logic loadn_q;
    logic pgt_q;
    logic load_ev;
    logic tick;

    bcd_t so_next, st_next, mo_next, mt_next;
    bcd_t so_wrap;
    logic so_borrow, st_borrow, mo_borrow;
    logic underflow;
    logic dec_zero;

    // Register the raw strobes so each edge yields exactly one event
    always_ff @(posedge clk) begin
        if (rst) begin
            loadn_q <= 1'b1;
            pgt_q   <= 1'b0;
        end else begin
            loadn_q <= loadn;
            pgt_q   <= pgt_1Hz;
        end
    end

    assign load_ev = loadn_q & ~loadn;
    assign tick    = ~pgt_q & pgt_1Hz;

    assign zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // Seconds-ones reloads 9 on a seconds-tens borrow, but the configured
    // wrap value when the borrow reaches into the minutes.
    assign so_wrap = (sec_tens == 4'd0) ? SEC_ONES_WRAP : BCD_MAX;

    bcd_digit_dec u_sec_ones (
        .digit      (sec_ones),
        .borrow_in  (1'b1),
        .wrap       (so_wrap),
        .next_digit (so_next),
        .borrow_out (so_borrow)
    );

    bcd_digit_dec u_sec_tens (
        .digit      (sec_tens),
        .borrow_in  (so_borrow),
        .wrap       (SEC_TENS_WRAP),
        .next_digit (st_next),
        .borrow_out (st_borrow)
    );

    bcd_digit_dec u_min_ones (
        .digit      (min_ones),
        .borrow_in  (st_borrow),
        .wrap       (BCD_MAX),
        .next_digit (mo_next),
        .borrow_out (mo_borrow)
    );

    bcd_digit_dec u_min_tens (
        .digit      (min_tens),
        .borrow_in  (mo_borrow),
        .wrap       (BCD_MAX),
        .next_digit (mt_next),
        .borrow_out (underflow)
    );

    // A borrow out of the top digit means the value was 0000: hold, never wrap.
    assign dec_zero = (mt_next == 4'd0) && (mo_next == 4'd0) &&
                      (st_next == 4'd0) && (so_next == 4'd0) && ~underflow;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a final tick takes priority over a pause request
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (count_en && !zero) next_state = RUN;
            RUN: begin
                if (tick && dec_zero)  next_state = DONE;
                else if (!count_en)    next_state = IDLE;
            end
            DONE: if (!count_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        running = (state == RUN);
    end

    // Digit registers: countdown in RUN, key entry in IDLE, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (state == RUN) begin
            if (tick && !underflow) begin
                min_tens <= mt_next;
                min_ones <= mo_next;
                sec_tens <= st_next;
                sec_ones <= so_next;
            end
        end else if (state == IDLE && load_ev && (D < KEY_INVALID_MIN)) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= D;
        end
    end

`ifdef TIMER_DONE_PULSE_EN
    // One-clock completion pulse aligned with the first DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == RUN) && (next_state == DONE);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: table of key/tick/wait vectors
// followed by hand-written countdown, pause, zero-guard and reset sequences.
module tb_bcd_countdown_timer;

    localparam int OP_KEY  = 0;
    localparam int OP_TICK = 1;
    localparam int OP_WAIT = 2;

    typedef struct {
        int          op;
        logic [3:0]  d;
        logic        en;
        logic [15:0] dig;
        logic        z;
        logic        r;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1Hz = 1'b0;
    logic       count_en = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       zero, running;
    logic [15:0] digits;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl [15];

`ifdef TIMER_DONE_PULSE_EN
    logic done;
    int   done_cnt = 0;
    int   done_base;
    always @(negedge clk) if (done === 1'b1) done_cnt++;
`endif

    bcd_countdown_timer dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .loadn    (loadn),
        .pgt_1Hz  (pgt_1Hz),
        .count_en (count_en),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .running  (running)
`ifdef TIMER_DONE_PULSE_EN
        ,
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] dig, input logic z, input logic r);
        chk16({name, "_digits"}, digits, dig);
        chk1({name, "_zero"}, zero, z);
        chk1({name, "_running"}, running, r);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Key held for 100 clocks, then released
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        D = d;
        loadn = 1'b0;
        clocks(100);
        loadn = 1'b1;
        clocks(5);
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        pgt_1Hz = 1'b1;
        clocks(5);
        pgt_1Hz = 1'b0;
        clocks(5);
    endtask

    initial begin
        tbl[0]  = '{OP_KEY,  4'd1,  1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[1]  = '{OP_KEY,  4'd3,  1'b0, 16'h0013, 1'b0, 1'b0};
        tbl[2]  = '{OP_KEY,  4'd0,  1'b0, 16'h0130, 1'b0, 1'b0};
        tbl[3]  = '{OP_KEY,  4'd12, 1'b0, 16'h0130, 1'b0, 1'b0};
        tbl[4]  = '{OP_KEY,  4'd15, 1'b0, 16'h0130, 1'b0, 1'b0};
        tbl[5]  = '{OP_KEY,  4'd4,  1'b0, 16'h1304, 1'b0, 1'b0};
        tbl[6]  = '{OP_KEY,  4'd5,  1'b0, 16'h3045, 1'b0, 1'b0};
        tbl[7]  = '{OP_KEY,  4'd0,  1'b0, 16'h0450, 1'b0, 1'b0};
        tbl[8]  = '{OP_KEY,  4'd1,  1'b0, 16'h4501, 1'b0, 1'b0};
        tbl[9]  = '{OP_KEY,  4'd0,  1'b0, 16'h5010, 1'b0, 1'b0};
        tbl[10] = '{OP_KEY,  4'd0,  1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[11] = '{OP_WAIT, 4'd0,  1'b1, 16'h0100, 1'b0, 1'b1};
        tbl[12] = '{OP_KEY,  4'd7,  1'b1, 16'h0100, 1'b0, 1'b1};
        tbl[13] = '{OP_TICK, 4'd0,  1'b1, 16'h0059, 1'b0, 1'b1};
        tbl[14] = '{OP_TICK, 4'd0,  1'b1, 16'h0058, 1'b0, 1'b1};

        // Reset held for two clocks
        clocks(2);
        rst = 1'b0;
        check_all("reset", 16'h0000, 1'b1, 1'b0);

        // Table: entry, invalid keys, overflow, start, load-in-RUN, first ticks
        for (int i = 0; i < 15; i++) begin
            count_en = tbl[i].en;
            case (tbl[i].op)
                OP_KEY:  press(tbl[i].d);
                OP_TICK: tick_pulse();
                default: clocks(3);
            endcase
            check_all($sformatf("vec%0d", i), tbl[i].dig, tbl[i].z, tbl[i].r);
        end

        // Count down to 00:45
        repeat (13) tick_pulse();
        check_all("at_0045", 16'h0045, 1'b0, 1'b1);

        // Pause: digits hold across ticks
        count_en = 1'b0;
        clocks(3);
        check_all("paused", 16'h0045, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick_pulse();
            chk16($sformatf("pause_tick%0d", i), digits, 16'h0045);
        end

        // Resume
        count_en = 1'b1;
        clocks(3);
        check_all("resumed", 16'h0045, 1'b0, 1'b1);
        tick_pulse();
        check_all("resume_tick", 16'h0044, 1'b0, 1'b1);

        // Tick and load event on the same edge: decrement only
        @(negedge clk);
        D = 4'd7;
        loadn = 1'b0;
        pgt_1Hz = 1'b1;
        clocks(5);
        loadn = 1'b1;
        pgt_1Hz = 1'b0;
        clocks(5);
        check_all("tick_with_load", 16'h0043, 1'b0, 1'b1);

        // Run to completion
`ifdef TIMER_DONE_PULSE_EN
        done_base = done_cnt;
`endif
        repeat (43) tick_pulse();
        check_all("done", 16'h0000, 1'b1, 1'b0);
`ifdef TIMER_DONE_PULSE_EN
        chk16("done_pulse_count", 16'(done_cnt - done_base), 16'd1);
`endif
        tick_pulse();
        check_all("done_extra_tick", 16'h0000, 1'b1, 1'b0);

        // Zero guard: enable with 0000 stays idle, ticks do not wrap
        count_en = 1'b0;
        clocks(3);
        count_en = 1'b1;
        clocks(3);
        chk1("zero_guard_idle", running, 1'b0);
        tick_pulse();
        check_all("zero_guard_tick", 16'h0000, 1'b1, 1'b0);
        count_en = 1'b0;
        clocks(2);

        // Seconds above 59 count linearly
        press(4'd9);
        press(4'd0);
        chk16("enter_0090", digits, 16'h0090);
        count_en = 1'b1;
        clocks(3);
        tick_pulse();
        check_all("tick_0090", 16'h0089, 1'b0, 1'b1);
        count_en = 1'b0;
        clocks(3);

        // Minute pair borrow 10:00 -> 09:59
        press(4'd1);
        press(4'd0);
        press(4'd0);
        press(4'd0);
        chk16("enter_1000", digits, 16'h1000);
        count_en = 1'b1;
        clocks(3);
        tick_pulse();
        check_all("tick_1000", 16'h0959, 1'b0, 1'b1);
        count_en = 1'b0;
        clocks(3);

        // Reset in the middle of a countdown
        press(4'd0);
        press(4'd0);
        press(4'd3);
        press(4'd0);
        chk16("enter_0030", digits, 16'h0030);
        count_en = 1'b1;
        clocks(3);
        chk1("run_0030", running, 1'b1);
        rst = 1'b1;
        clocks(2);
        rst = 1'b0;
        check_all("mid_reset", 16'h0000, 1'b1, 1'b0);
        clocks(2);
        chk1("post_reset_idle", running, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
